// File: rtl/seq_multichannel_sync.sv
// Multi-channel custom-sequence generator: per-channel shadow/active config banks,
// loop-boundary commit, continuous/burst modes and masked synchronous start/stop.
module seq_multichannel_sync #(
  parameter int NUM_CHANNELS  = 8,
  parameter int CH_IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int DIVIDER_WIDTH = 16,
  parameter int SEQ_MAX_BITS  = 64,
  parameter int LEN_WIDTH     = $clog2(SEQ_MAX_BITS + 1),
  parameter int REPEAT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_IDX_WIDTH-1:0]  cfg_ch_index,
  input  logic [DIVIDER_WIDTH-1:0] cfg_freq_div,
  input  logic [SEQ_MAX_BITS-1:0]  cfg_seq_data,
  input  logic [LEN_WIDTH-1:0]     cfg_seq_len,
  input  logic                     cfg_mode,
  input  logic [REPEAT_WIDTH-1:0]  cfg_repeat,
  input  logic                     cfg_idle_level,
  input  logic                     cfg_enable,
  input  logic                     cfg_write,
  input  logic [NUM_CHANNELS-1:0]  commit_mask,
  input  logic                     commit_strobe,
  input  logic [NUM_CHANNELS-1:0]  start_mask,
  input  logic                     start_strobe,
  input  logic [NUM_CHANNELS-1:0]  stop_mask,
  input  logic                     stop_strobe,
  output logic [NUM_CHANNELS-1:0]  seq_out_vector,
  output logic [NUM_CHANNELS-1:0]  busy_vector,
  output logic [NUM_CHANNELS-1:0]  pending_vector,
  output logic [NUM_CHANNELS-1:0]  done_pulse_vector
);

  localparam int IDX_W = (SEQ_MAX_BITS > 1) ? $clog2(SEQ_MAX_BITS) : 1;

  typedef struct packed {
    logic [DIVIDER_WIDTH-1:0] div;
    logic [SEQ_MAX_BITS-1:0]  data;
    logic [LEN_WIDTH-1:0]     len;
    logic                     mode;
    logic [REPEAT_WIDTH-1:0]  rep;
    logic                     idle;
    logic                     en;
  } cfg_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  cfg_t cfg_in;

  always_comb begin
    cfg_in.div  = cfg_freq_div;
    cfg_in.data = cfg_seq_data;
    cfg_in.len  = (cfg_seq_len > LEN_WIDTH'(SEQ_MAX_BITS)) ? LEN_WIDTH'(SEQ_MAX_BITS)
                                                          : cfg_seq_len;
    cfg_in.mode = cfg_mode;
    cfg_in.rep  = cfg_repeat;
    cfg_in.idle = cfg_idle_level;
    cfg_in.en   = cfg_enable;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    cfg_t                     shadow_q, shadow_d;
    cfg_t                     active_q, active_d;
    state_t                   state_q, state_d;
    logic [DIVIDER_WIDTH-1:0] div_q, div_d;
    logic [IDX_W-1:0]         bit_q, bit_d;
    logic [REPEAT_WIDTH-1:0]  loop_q, loop_d;
    logic                     pend_q, pend_d;
    logic                     out_q, out_d;
    logic                     done_q, done_d;
    logic                     wr, start, stop, commit;
    logic                     div_end, boundary, last_loop;
    logic [REPEAT_WIDTH-1:0]  rep_m1;

    // Out-of-range indices match no channel and are dropped here.
    assign wr     = cfg_write && (cfg_ch_index == CH_IDX_WIDTH'(g));
    assign start  = start_strobe  && start_mask[g];
    assign stop   = stop_strobe   && stop_mask[g];
    assign commit = commit_strobe && commit_mask[g];

    assign rep_m1    = (active_q.rep == '0) ? '0 : active_q.rep - 1'b1;
    assign div_end   = (div_q == active_q.div);
    assign boundary  = div_end && (LEN_WIDTH'(bit_q) == active_q.len - 1'b1);
    assign last_loop = (loop_q == rep_m1);

    always_comb begin
      shadow_d = wr ? cfg_in : shadow_q;
      active_d = active_q;
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      loop_d   = loop_q;
      pend_d   = pend_q;
      out_d    = out_q;
      done_d   = 1'b0;
      case (state_q)
        S_IDLE: begin
          pend_d = 1'b0;
          out_d  = active_q.idle;
          // Commit lands first so a coincident start runs the new config.
          if (commit) active_d = shadow_q;
          if (!stop && start && active_d.en && (active_d.len != '0)) begin
            state_d = S_RUN;
            div_d   = '0;
            bit_d   = '0;
            loop_d  = '0;
            out_d   = active_d.data[0];
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
            out_d   = active_q.idle;
            pend_d  = 1'b0;
          end else if (start) begin
            div_d  = '0;
            bit_d  = '0;
            loop_d = '0;
            out_d  = active_q.data[0];
            if (commit) pend_d = 1'b1;
          end else if (boundary) begin
            div_d = '0;
            bit_d = '0;
            if (pend_q || commit) begin
              active_d = shadow_q;
              pend_d   = 1'b0;
              loop_d   = '0;
              if (!shadow_q.en || (shadow_q.len == '0)) begin
                state_d = S_IDLE;
                out_d   = active_q.idle;
              end else begin
                out_d = shadow_q.data[0];
              end
            end else if (active_q.mode && last_loop) begin
              state_d = S_IDLE;
              out_d   = active_q.idle;
              done_d  = 1'b1;
            end else begin
              loop_d = loop_q + 1'b1;
              out_d  = active_q.data[0];
            end
          end else begin
            if (commit) pend_d = 1'b1;
            if (div_end) begin
              div_d = '0;
              bit_d = bit_q + 1'b1;
              out_d = active_q.data[bit_d];
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
        state_q  <= S_IDLE;
        div_q    <= '0;
        bit_q    <= '0;
        loop_q   <= '0;
        pend_q   <= 1'b0;
        out_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        state_q  <= state_d;
        div_q    <= div_d;
        bit_q    <= bit_d;
        loop_q   <= loop_d;
        pend_q   <= pend_d;
        out_q    <= out_d;
        done_q   <= done_d;
      end
    end

    assign seq_out_vector[g]    = out_q;
    assign busy_vector[g]       = (state_q == S_RUN);
    assign pending_vector[g]    = pend_q;
    assign done_pulse_vector[g] = done_q;
  end

endmodule

// File: tb/tb_seq_multichannel_sync.sv
// Bench for seq_multichannel_sync: directed scenarios plus random traffic, all
// cycles compared against a phase-counting reference model.
module tb_seq_multichannel_sync;

  localparam int NCH  = 6;
  localparam int CIW  = 3;
  localparam int DVW  = 16;
  localparam int SMB  = 64;
  localparam int LNW  = 7;
  localparam int RPW  = 8;

  logic           clk;
  logic           rst_n;
  logic [CIW-1:0] cfg_ch_index;
  logic [DVW-1:0] cfg_freq_div;
  logic [SMB-1:0] cfg_seq_data;
  logic [LNW-1:0] cfg_seq_len;
  logic           cfg_mode;
  logic [RPW-1:0] cfg_repeat;
  logic           cfg_idle_level;
  logic           cfg_enable;
  logic           cfg_write;
  logic [NCH-1:0] commit_mask;
  logic           commit_strobe;
  logic [NCH-1:0] start_mask;
  logic           start_strobe;
  logic [NCH-1:0] stop_mask;
  logic           stop_strobe;
  logic [NCH-1:0] seq_out_vector;
  logic [NCH-1:0] busy_vector;
  logic [NCH-1:0] pending_vector;
  logic [NCH-1:0] done_pulse_vector;

  seq_multichannel_sync #(
    .NUM_CHANNELS (NCH),
    .CH_IDX_WIDTH (CIW),
    .DIVIDER_WIDTH(DVW),
    .SEQ_MAX_BITS (SMB),
    .LEN_WIDTH    (LNW),
    .REPEAT_WIDTH (RPW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_ch_index     (cfg_ch_index),
    .cfg_freq_div     (cfg_freq_div),
    .cfg_seq_data     (cfg_seq_data),
    .cfg_seq_len      (cfg_seq_len),
    .cfg_mode         (cfg_mode),
    .cfg_repeat       (cfg_repeat),
    .cfg_idle_level   (cfg_idle_level),
    .cfg_enable       (cfg_enable),
    .cfg_write        (cfg_write),
    .commit_mask      (commit_mask),
    .commit_strobe    (commit_strobe),
    .start_mask       (start_mask),
    .start_strobe     (start_strobe),
    .stop_mask        (stop_mask),
    .stop_strobe      (stop_strobe),
    .seq_out_vector   (seq_out_vector),
    .busy_vector      (busy_vector),
    .pending_vector   (pending_vector),
    .done_pulse_vector(done_pulse_vector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a running channel is described by its cycle phase within
  // the current loop and the number of completed loops.
  typedef struct {
    int unsigned div;
    logic [63:0] data;
    int unsigned len;
    bit          mode;
    int unsigned rep;
    bit          idle;
    bit          en;
  } mcfg_t;

  mcfg_t       m_sh   [NCH];
  mcfg_t       m_act  [NCH];
  bit          m_run  [NCH];
  int unsigned m_phase[NCH];
  int unsigned m_loops[NCH];
  bit          m_pend [NCH];
  bit          m_out  [NCH];
  bit          m_done [NCH];

  function automatic mcfg_t zero_cfg();
    mcfg_t z;
    z.div = 0; z.data = '0; z.len = 0; z.mode = 0; z.rep = 0; z.idle = 0; z.en = 0;
    return z;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = zero_cfg(); m_act[i] = zero_cfg();
      m_run[i] = 0; m_phase[i] = 0; m_loops[i] = 0;
      m_pend[i] = 0; m_out[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      bit st, sa, cm;
      mcfg_t sh_old;
      int unsigned period, looplen, reps;
      st = stop_strobe && stop_mask[ch];
      sa = start_strobe && start_mask[ch];
      cm = commit_strobe && commit_mask[ch];
      sh_old = m_sh[ch];
      m_done[ch] = 0;
      if (!m_run[ch]) begin
        m_pend[ch] = 0;
        m_out[ch] = m_act[ch].idle;
        if (cm) m_act[ch] = sh_old;
        if (!st && sa && m_act[ch].en && m_act[ch].len != 0) begin
          m_run[ch] = 1; m_phase[ch] = 0; m_loops[ch] = 0;
          m_out[ch] = m_act[ch].data[0];
        end
      end else begin
        period  = m_act[ch].div + 1;
        looplen = m_act[ch].len * period;
        reps    = (m_act[ch].rep == 0) ? 1 : m_act[ch].rep;
        if (st) begin
          m_run[ch] = 0; m_out[ch] = m_act[ch].idle; m_pend[ch] = 0;
        end else if (sa) begin
          m_phase[ch] = 0; m_loops[ch] = 0; m_out[ch] = m_act[ch].data[0];
          if (cm) m_pend[ch] = 1;
        end else if (m_phase[ch] == looplen - 1) begin
          m_phase[ch] = 0;
          if (m_pend[ch] || cm) begin
            bit old_idle;
            old_idle = m_act[ch].idle;
            m_act[ch] = sh_old; m_pend[ch] = 0; m_loops[ch] = 0;
            if (!sh_old.en || sh_old.len == 0) begin
              m_run[ch] = 0; m_out[ch] = old_idle;
            end else begin
              m_out[ch] = sh_old.data[0];
            end
          end else if (m_act[ch].mode && m_loops[ch] + 1 >= reps) begin
            m_run[ch] = 0; m_out[ch] = m_act[ch].idle; m_done[ch] = 1;
          end else begin
            m_loops[ch]++; m_out[ch] = m_act[ch].data[0];
          end
        end else begin
          m_phase[ch]++;
          m_out[ch] = m_act[ch].data[m_phase[ch] / period];
          if (cm) m_pend[ch] = 1;
        end
      end
    end
    if (cfg_write && int'(cfg_ch_index) < NCH) begin
      int idx;
      idx = int'(cfg_ch_index);
      m_sh[idx].div  = cfg_freq_div;
      m_sh[idx].data = cfg_seq_data;
      m_sh[idx].len  = (cfg_seq_len > 64) ? 64 : cfg_seq_len;
      m_sh[idx].mode = cfg_mode;
      m_sh[idx].rep  = cfg_repeat;
      m_sh[idx].idle = cfg_idle_level;
      m_sh[idx].en   = cfg_enable;
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_out, e_busy, e_pend, e_done;
    for (int i = 0; i < NCH; i++) begin
      e_out[i] = m_out[i]; e_busy[i] = m_run[i];
      e_pend[i] = m_pend[i]; e_done[i] = m_done[i];
    end
    check_eq("seq_out", 64'(seq_out_vector), 64'(e_out));
    check_eq("busy",    64'(busy_vector),    64'(e_busy));
    check_eq("pending", 64'(pending_vector), 64'(e_pend));
    check_eq("done",    64'(done_pulse_vector), 64'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
    cfg_write = 0; commit_strobe = 0; start_strobe = 0; stop_strobe = 0;
  endtask

  task automatic write_cfg(input int ch, input int dv, input logic [63:0] d, input int ln,
                           input bit md, input int rp, input bit idl, input bit en);
    cfg_ch_index = CIW'(ch); cfg_freq_div = DVW'(dv); cfg_seq_data = d;
    cfg_seq_len = LNW'(ln); cfg_mode = md; cfg_repeat = RPW'(rp);
    cfg_idle_level = idl; cfg_enable = en; cfg_write = 1;
    tick();
  endtask

  task automatic do_commit(input logic [NCH-1:0] m);
    commit_mask = m; commit_strobe = 1; tick();
  endtask

  task automatic do_start(input logic [NCH-1:0] m);
    start_mask = m; start_strobe = 1; tick();
  endtask

  task automatic do_stop(input logic [NCH-1:0] m);
    stop_mask = m; stop_strobe = 1; tick();
  endtask

  initial begin
    logic [3:0] pat;
    bit found;
    int r;
    rst_n = 0; cfg_ch_index = '0; cfg_freq_div = '0; cfg_seq_data = '0; cfg_seq_len = '0;
    cfg_mode = 0; cfg_repeat = '0; cfg_idle_level = 0; cfg_enable = 0; cfg_write = 0;
    commit_mask = '0; commit_strobe = 0; start_mask = '0; start_strobe = 0;
    stop_mask = '0; stop_strobe = 0;
    model_reset();
    tick(); tick();
    check_eq("rst_out",  64'(seq_out_vector), 64'd0);
    check_eq("rst_busy", 64'(busy_vector), 64'd0);
    rst_n = 1;
    tick();

    // Continuous pattern 0,1,1,0 with 4-cycle bits on ch0.
    write_cfg(0, 3, 64'b0110, 4, 0, 0, 0, 1);
    do_commit(6'h01);
    do_start(6'h01);
    check_eq("d1_busy", 64'(busy_vector[0]), 64'd1);
    pat = 4'b0110;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      check_eq("d1_out", 64'(seq_out_vector[0]), 64'(pat[(k / 4) % 4]));
    end

    // Burst of three 2-bit loops on ch2, idle level high.
    write_cfg(2, 0, 64'b01, 2, 1, 3, 1, 1);
    do_commit(6'h04);
    do_start(6'h04);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k < 6) begin
        check_eq("d2_out", 64'(seq_out_vector[2]), 64'((k % 2) == 0));
        check_eq("d2_busy", 64'(busy_vector[2]), 64'd1);
      end else begin
        check_eq("d2_idle", 64'(seq_out_vector[2]), 64'd1);
        check_eq("d2_done", 64'(done_pulse_vector[2]), 64'(k == 6));
        check_eq("d2_busyoff", 64'(busy_vector[2]), 64'd0);
      end
    end

    // Mid-loop commit on ch1 waits for the loop boundary.
    write_cfg(1, 1, 64'hFF, 8, 0, 0, 0, 1);
    do_commit(6'h02);
    do_start(6'h02);
    for (int k = 0; k < 5; k++) tick();
    write_cfg(1, 1, 64'h00, 8, 0, 0, 0, 1);
    do_commit(6'h02);
    check_eq("d3_pend", 64'(pending_vector[1]), 64'd1);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!found && seq_out_vector[1] == 1'b0) begin
        found = 1;
        check_eq("d3_pendclr", 64'(pending_vector[1]), 64'd0);
      end
    end
    check_eq("d3_seen", 64'(found), 64'd1);

    // Phase-aligned start of ch0..3, then masked stop of ch0 and ch2.
    do_stop(6'h3F);
    for (int i = 0; i < 4; i++)
      write_cfg(i, i, {$urandom, $urandom}, 3, 0, 0, (i % 2) == 0, 1);
    do_commit(6'h0F);
    do_start(6'h0F);
    check_eq("d4_busy", 64'(busy_vector[3:0]), 64'hF);
    for (int k = 0; k < 7; k++) tick();
    do_stop(6'h05);
    check_eq("d4_stopbusy", 64'(busy_vector[3:0]), 64'hA);
    check_eq("d4_idle0", 64'(seq_out_vector[0]), 64'd1);
    check_eq("d4_idle2", 64'(seq_out_vector[2]), 64'd1);
    check_eq("d4_nodone", 64'(done_pulse_vector), 64'd0);

    // Invalid configs refuse to start.
    write_cfg(4, 0, 64'hF, 0, 0, 0, 1, 1);
    write_cfg(5, 0, 64'hF, 5, 0, 0, 1, 0);
    do_commit(6'h30);
    do_start(6'h30);
    check_eq("d5_busy", 64'(busy_vector[5:4]), 64'd0);
    check_eq("d5_idle", 64'(seq_out_vector[5:4]), 64'h3);

    // Length 100 clamps to 64: bit 63 then straight back to bit 0.
    write_cfg(4, 0, 64'h8000_0000_0000_0001, 100, 0, 0, 0, 1);
    do_commit(6'h10);
    do_start(6'h10);
    check_eq("clamp_b0", 64'(seq_out_vector[4]), 64'd1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 62) check_eq("clamp_b62", 64'(seq_out_vector[4]), 64'd0);
      if (k == 63) check_eq("clamp_b63", 64'(seq_out_vector[4]), 64'd1);
      if (k == 64) check_eq("clamp_wrap", 64'(seq_out_vector[4]), 64'd1);
    end

    // Asynchronous reset in the middle of a long burst.
    write_cfg(2, 2, 64'h5, 4, 1, 200, 1, 1);
    do_commit(6'h04);
    do_start(6'h04);
    for (int k = 0; k < 10; k++) tick();
    #2 rst_n = 0;
    #1;
    check_eq("arst_out",  64'(seq_out_vector), 64'd0);
    check_eq("arst_busy", 64'(busy_vector), 64'd0);
    check_eq("arst_pend", 64'(pending_vector), 64'd0);
    check_eq("arst_done", 64'(done_pulse_vector), 64'd0);
    tick(); tick();
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("arst_nodone", 64'(done_pulse_vector), 64'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        cfg_write = 1;
        cfg_ch_index = CIW'($urandom_range(0, 7));
        cfg_freq_div = DVW'($urandom_range(0, 3));
        cfg_seq_data = {$urandom, $urandom};
        r = int'($urandom_range(0, 19));
        cfg_seq_len = (r == 19) ? LNW'(100) : (r == 18) ? LNW'(0) : LNW'($urandom_range(1, 10));
        cfg_mode = 1'($urandom_range(0, 1));
        cfg_repeat = RPW'($urandom_range(0, 3));
        cfg_idle_level = 1'($urandom_range(0, 1));
        cfg_enable = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        commit_strobe = 1; commit_mask = NCH'($urandom);
      end
      if ($urandom_range(0, 11) == 0) begin
        start_strobe = 1; start_mask = NCH'($urandom);
      end
      if ($urandom_range(0, 24) == 0) begin
        stop_strobe = 1; stop_mask = NCH'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
